// File: rtl/ntt_ctrl.sv
// NTT transform sequencer: walks 8 layers x 128 butterflies, issues coefficient reads,
// tracks in-flight butterflies in an address FIFO and writes results back in issue order.
module ntt_ctrl #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       inverse,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [7:0] zeta_addr,
  output logic [2:0] bf_mode,
  output logic       bf_validi,
  input  logic       bf_valido,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic       err,
  output logic [1:0] state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  // Handshake: one read per rd_en cycle; bf_valido is a one-cycle strobe per finished
  // butterfly, consumed in that same cycle against the FIFO head (no backpressure).
  state_t           state, state_nx;
  logic [2:0]       layer;
  logic [6:0]       bidx;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic             stall, pop, drained;

  assign stall   = (count == CNT_STALL);
  assign drained = (count == '0);
  assign pop     = bf_valido && !drained;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: if (!stall && bidx == 7'd127) state_nx = DRAIN;
      DRAIN: if (drained) state_nx = (layer == 3'd7) ? FIN : ISSUE;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == FIN);
    rd_en     = (state == ISSUE) && !stall;
    state_dbg = state;
  end

  // Layer/butterfly counters and the mode latched at start.
  always_ff @(posedge clk) begin
    if (rst) begin
      layer     <= '0;
      bidx      <= '0;
      bf_mode   <= '0;
      bf_validi <= 1'b0;
    end else begin
      bf_validi <= rd_en;
      if (state == IDLE && start) begin
        layer   <= '0;
        bidx    <= '0;
        bf_mode <= {2'b00, inverse};
      end else begin
        if (rd_en) bidx <= bidx + 7'd1;
        if (state == DRAIN && drained && layer != 3'd7) layer <= layer + 3'd1;
      end
    end
  end

  // Address generation: all strides are powers of two, so divide/mod become shifts/masks.
  logic [3:0] fwd_sh;
  logic [7:0] b_ext, len, grp, addr_a;
  logic [8:0] inv_zeta;

  always_comb begin
    b_ext    = {1'b0, bidx};
    fwd_sh   = 4'd7 - {1'b0, layer};
    inv_zeta = '0;
    if (bf_mode[0]) begin
      len       = 8'd1 << layer;
      grp       = b_ext >> layer;
      addr_a    = (grp << ({1'b0, layer} + 4'd1)) | (b_ext & (len - 8'd1));
      inv_zeta  = (9'd1 << (4'd8 - {1'b0, layer})) - 9'd1 - {1'b0, grp};
      zeta_addr = inv_zeta[7:0];
    end else begin
      len       = 8'd128 >> layer;
      grp       = b_ext >> fwd_sh;
      addr_a    = (grp << (fwd_sh + 4'd1)) | (b_ext & (len - 8'd1));
      zeta_addr = (8'd1 << layer) + grp;
    end
    rd_addr_a = addr_a;
    rd_addr_b = addr_a + len;
  end

  always_ff @(posedge clk) begin
    if (rd_en) fifo_mem[wr_ptr] <= {rd_addr_a, rd_addr_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (rd_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({rd_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A result with nothing outstanding is a protocol violation; sticky until reset.
      if (bf_valido && drained) err <= 1'b1;
    end
  end

  assign wr_en = pop;
  assign {wr_addr_a, wr_addr_b} = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: randomized butterfly latency / start noise against an
// arithmetic reference of the NTT address schedule with an in-order write scoreboard.
module tb_ntt_ctrl;
  localparam int FIFO_DEPTH = 16;

  logic       clk, rst, start, inverse, bf_valido;
  logic       busy, done, rd_en, bf_validi, wr_en, err;
  logic [7:0] rd_addr_a, rd_addr_b, zeta_addr, wr_addr_a, wr_addr_b;
  logic [2:0] bf_mode;
  logic [1:0] state_dbg;

  ntt_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse),
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .zeta_addr(zeta_addr),
    .bf_mode(bf_mode), .bf_validi(bf_validi), .bf_valido(bf_valido),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .err(err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // scoreboard state
  logic [23:0] exp_q[$];
  logic [15:0] wr_q[$];
  bit          pipe_q[$];
  logic [23:0] issue_log [1024];
  int  issue_cnt, wr_cnt, done_cnt, max_occ, stall_cnt;
  int  barrier_err, validi_err, mode_err, busy_err, wr_en_err, err_flag_err, stall_err;
  bit  exp_err, prev_rd, noise_on;

  function automatic logic [23:0] ref_issue(input bit inv, input int l, input int b);
    int len, g, a, z;
    if (!inv) begin
      len = 128 / (2 ** l);
      g   = b / len;
      z   = (2 ** l) + g;
    end else begin
      len = 2 ** l;
      g   = b / len;
      z   = (2 ** (8 - l)) - 1 - g;
    end
    a = g * 2 * len + (b % len);
    return {8'(a), 8'(a + len), 8'(z)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; bf_valido = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pipe_q.delete(); wr_q.delete();
    exp_err = 1'b0; prev_rd = 1'b0;
  endtask

  // one clock of driving + sampling; inputs for the next edge are set at the end
  task automatic step(input bit inv, input bit in_run);
    logic [23:0] got;
    int occ, wr_before;
    @(negedge clk);
    bf_valido = (pipe_q.size() > 0) ? pipe_q.pop_front() : 1'b0;
    #1;
    occ = wr_q.size();
    if (occ > max_occ) max_occ = occ;
    if (err !== exp_err) err_flag_err++;
    if (bf_valido && occ == 0) exp_err = 1'b1;
    if (wr_en !== (bf_valido && occ != 0)) wr_en_err++;
    wr_before = wr_cnt;
    if (wr_en && wr_q.size() != 0) begin
      check("wr_pair", {16'd0, wr_addr_a, wr_addr_b}, {16'd0, wr_q.pop_front()});
      wr_cnt++;
    end
    if (bf_validi !== prev_rd) validi_err++;
    prev_rd = rd_en;
    if (occ >= FIFO_DEPTH - 1) begin
      if (rd_en) stall_err++;
      else stall_cnt++;
    end
    if (rd_en) begin
      got = {rd_addr_a, rd_addr_b, zeta_addr};
      if (exp_q.size() != 0) check("issue", got, exp_q.pop_front());
      if (wr_before < 128 * (issue_cnt / 128)) barrier_err++;
      if (issue_cnt < 1024) issue_log[issue_cnt] = got;
      issue_cnt++;
      wr_q.push_back({rd_addr_a, rd_addr_b});
    end
    if (in_run && !busy) busy_err++;
    if (busy && bf_mode !== {2'b00, inv}) mode_err++;
    if (done) done_cnt++;
    pipe_q.push_back(bf_validi);
    start   = noise_on && !done && ($urandom_range(0, 7) == 0);
    inverse = noise_on ? 1'($urandom_range(0, 1)) : inv;
  endtask

  task automatic run_transform(input bit inv, input int lat, input int stop_at);
    int cycles;
    exp_q.delete(); wr_q.delete(); pipe_q.delete();
    for (int l = 0; l < 8; l++)
      for (int b = 0; b < 128; b++) exp_q.push_back(ref_issue(inv, l, b));
    repeat (lat) pipe_q.push_back(1'b0);
    issue_cnt = 0; wr_cnt = 0; done_cnt = 0; max_occ = 0; stall_cnt = 0;
    barrier_err = 0; validi_err = 0; mode_err = 0; busy_err = 0;
    wr_en_err = 0; err_flag_err = 0; stall_err = 0;
    @(negedge clk);
    start = 1'b1; inverse = inv;
    pipe_q.push_back(1'b0);
    cycles = 0;
    while (done_cnt == 0 && cycles < 20000 && !(stop_at > 0 && issue_cnt >= stop_at)) begin
      step(inv, 1'b1);
      cycles++;
    end
    if (stop_at > 0) begin
      check("stop_reached", issue_cnt, stop_at);
      return;
    end
    check("run_timeout", done_cnt, 1);
    noise_on = 1'b0;
    step(inv, 1'b0);
    check("busy_after_done", busy, 0);
    repeat (4) step(inv, 1'b0);
    check("issue_count", issue_cnt, 1024);
    check("write_count", wr_cnt, 1024);
    check("done_pulses", done_cnt, 1);
    check("exp_left", exp_q.size(), 0);
    check("wr_left", wr_q.size(), 0);
    check("barrier", barrier_err, 0);
    check("bf_validi", validi_err, 0);
    check("bf_mode", mode_err, 0);
    check("busy_run", busy_err, 0);
    check("wr_en", wr_en_err, 0);
    check("err_flag", err_flag_err, 0);
    check("stall_rd_en", stall_err, 0);
    check("max_outstanding_ok", max_occ <= FIFO_DEPTH - 1, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_bf_validi"}, bf_validi, 0);
    check({tag, "_bf_mode"}, bf_mode, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; inverse = 1'b0; bf_valido = 1'b0; noise_on = 1'b0;
    do_reset();
    #1;
    check_idle_outputs("reset");

    // forward, 8-cycle butterfly
    run_transform(1'b0, 8, 0);
    check("fwd_i0", issue_log[0], {8'd0, 8'd128, 8'd1});
    check("fwd_i1", issue_log[1], {8'd1, 8'd129, 8'd1});
    check("fwd_i2", issue_log[2], {8'd2, 8'd130, 8'd1});
    check("fwd_l7_b5", issue_log[7 * 128 + 5], {8'd10, 8'd11, 8'd133});

    // inverse, random latency
    run_transform(1'b1, $urandom_range(1, 12), 0);
    check("inv_l0_b0", issue_log[0], {8'd0, 8'd1, 8'd255});
    check("inv_l0_b127", issue_log[127], {8'd254, 8'd255, 8'd128});
    check("inv_l7_b0", issue_log[896], {8'd0, 8'd128, 8'd1});
    check("inv_l7_b127", issue_log[1023], {8'd127, 8'd255, 8'd1});

    // long latency forces stalls and exercises the drain barrier
    run_transform(1'b0, 20, 0);
    check("stalls_seen", stall_cnt > 0, 1);
    check("max_outstanding", max_occ, FIFO_DEPTH - 1);

    // start / inverse noise while busy
    for (int r = 0; r < 2; r++) begin
      bit inv_r;
      inv_r = 1'($urandom_range(0, 1));
      noise_on = 1'b1;
      run_transform(inv_r, $urandom_range(1, 20), 0);
    end

    // reset in the middle of layer 3
    noise_on = 1'b0;
    run_transform(1'b0, 8, 3 * 128 + 41);
    check("mid_l3_b40", issue_log[3 * 128 + 40], {8'd72, 8'd88, 8'd10});
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    bf_valido = 1'b0;
    pipe_q.delete(); wr_q.delete();
    #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0; exp_err = 1'b0; prev_rd = 1'b0;
    run_transform(1'b0, $urandom_range(1, 20), 0);
    check("restart_i0", issue_log[0], {8'd0, 8'd128, 8'd1});

    // spurious result while idle
    @(negedge clk);
    bf_valido = 1'b1;
    #1;
    check("spur_wr_en", wr_en, 0);
    check("spur_err_before", err, 0);
    @(negedge clk);
    bf_valido = 1'b0;
    #1;
    check("spur_err_set", err, 1);
    exp_err = 1'b1;
    run_transform(1'b0, $urandom_range(1, 20), 0);
    check("spur_err_held", err, 1);
    do_reset();
    #1;
    check("spur_err_cleared", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl.md
NTT_CTRL -- requirements
Module: ntt_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, maximum number of outstanding butterflies (power of two, 4..32).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin transform; sampled only in IDLE.
REQ-005 inverse  input  1  0 = forward NTT, 1 = inverse NTT; sampled with start.
REQ-006 busy  output  1  high in every state other than IDLE.
REQ-007 done  output  1  one-cycle pulse when the transform completes.
REQ-008 rd_en  output  1  coefficient-memory read strobe (sync memory, 1-cycle read latency).
REQ-009 rd_addr_a, rd_addr_b  output  8 each  butterfly pair addresses (j, j+len).
REQ-010 zeta_addr  output  8  twiddle ROM address, issued with rd_en.
REQ-011 bf_mode  output  3  butterfly mode: 0 forward, 1 inverse; held constant while busy.
REQ-012 bf_validi  output  1  equals rd_en delayed one cycle.
REQ-013 bf_valido  input  1  butterfly result valid.
REQ-014 wr_en, wr_addr_a, wr_addr_b  output  1/8/8  write-back strobe and pair addresses.
REQ-015 err  output  1  sticky protocol error flag.

Function
REQ-016 FSM states: IDLE, ISSUE, DRAIN, FIN; IDLE->ISSUE on start; ISSUE->DRAIN after butterfly 127 of a layer is issued; DRAIN->ISSUE (layer+1) when outstanding==0 and layer<7; DRAIN->FIN when outstanding==0 and layer==7; FIN->IDLE unconditionally, with done=1 in FIN.
REQ-017 Counters: layer l (3 bit, 0..7), butterfly index b (7 bit, 0..127); both cleared on start; b wraps to 0 and l increments on each ISSUE->DRAIN->ISSUE transition.
REQ-018 Forward: len=128>>l; g=b>>(7-l); rd_addr_a=g*2*len+(b mod len); rd_addr_b=rd_addr_a+len; zeta_addr=(1<<l)+g.
REQ-019 Inverse: len=1<<l; g=b>>l; rd_addr_a=g*2*len+(b mod len); rd_addr_b=rd_addr_a+len; zeta_addr=(1<<(8-l))-1-g.
REQ-020 In ISSUE, rd_en=1 and b advances each cycle unless outstanding==FIFO_DEPTH-1 (stall: rd_en=0, b held).
REQ-021 On each rd_en, {rd_addr_a, rd_addr_b} is pushed into an address FIFO; on each bf_valido, the head is popped and driven on wr_addr_a/b with wr_en=bf_valido in the same cycle (combinational head).
REQ-022 outstanding = FIFO occupancy; simultaneous push and pop leaves the count unchanged.
REQ-023 No read of layer l+1 is issued before all writes of layer l have completed (DRAIN barrier).
REQ-024 bf_valido while the FIFO is empty: set err, no pop, wr_en=0; err clears only on reset.
REQ-025 start asserted while busy is ignored; inverse is latched at start and ignores later changes.
REQ-026 Outputs rd_en, bf_validi, wr_en, done are 0 in IDLE; address outputs are don't-care when their strobes are low.

Reset
REQ-027 rst in any state, including mid-ISSUE or DRAIN, forces IDLE, clears l, b, FIFO pointers, outstanding, err, bf_validi and bf_mode (0); busy=done=rd_en=wr_en=0 in the cycle after rst is sampled.
REQ-028 bf_valido arriving after reset for butterflies issued before reset is flagged via err (REQ-024); the environment resets the butterfly together with this block.

Verification
REQ-029 Forward, 8-cycle butterfly model: start, inverse=0 -> first three issues (0,128,z1), (1,129,z1), (2,130,z1); layer 7 issue b=5 -> (10,11,z133); exactly 1024 wr_en pulses, each write pair equals its issue pair in order; exactly one done pulse.
REQ-030 Inverse: start, inverse=1 -> layer 0 b=0 (0,1,z255), b=127 (254,255,z128); layer 7 b=0 (0,128,z1), b=127 (127,255,z1).
REQ-031 Barrier: model latency 20 with FIFO_DEPTH=16 -> outstanding never exceeds 15; rd_en stalls; no layer l+1 rd_en occurs before the final layer-l wr_en.
REQ-032 Reset mid-run: rst at layer 3, b=40 -> next cycle busy=0, rd_en=0; new start then reissues from (0,128,z1).
REQ-033 Spurious bf_valido in IDLE -> err=1, wr_en=0; err stays 1 through a full transform until rst.
REQ-034 start pulsed during ISSUE -> ignored; total issue count remains 1024 and done pulses once.
